// File: rtl/cla_word_sequencer.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice is reused once per nibble,
// LSB nibble first, with the carry chained through a register between passes.
module cla_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [IDXW-1:0]  idx;
  logic             carry_reg;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       nib_a, nib_b, nib_sum;
  logic             nib_cout;
  logic             last_nibble;

  // The shared four_bit_adder_cla slice: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] four_bit_adder_cla(input logic [3:0] a,
                                                    input logic [3:0] b,
                                                    input logic       cin);
    logic [3:0] p, g, c;
    logic       cout;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {cout, p ^ c};
  endfunction

  assign nib_a       = op_a[4*idx +: 4];
  assign nib_b       = op_b[4*idx +: 4];
  assign {nib_cout, nib_sum} = four_bit_adder_cla(nib_a, nib_b, carry_reg);
  assign last_nibble = (idx == IDXW'(NIBBLES - 1));

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_nibble) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result nibbles are written in place, so out_sum is cleared at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a      <= in_a;
            op_b      <= in_b;
            carry_reg <= in_carry;
            idx       <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
          end
        end
        ADD: begin
          out_sum[4*idx +: 4] <= nib_sum;
          carry_reg           <= nib_cout;
          idx                 <= idx + IDXW'(1);
          if (last_nibble) out_carry <= nib_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic model of a + b + cin.
module tb_cla_word_sequencer;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_sum;
  logic             exp_carry;

  cla_word_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; the handshake sides must never both be open.
  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic c);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_carry = c;
  endtask

  task automatic applyRandomNoise();
    applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 1)));
  endtask

  task automatic setExpected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic c);
    logic [WIDTH:0] total;
    total     = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
    exp_sum   = total[WIDTH-1:0];
    exp_carry = total[WIDTH];
  endtask

  task automatic acceptOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c);
    int waited = 0;
    while (!in_ready && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, a, b, c);
    tick();
    setExpected(a, b, c);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, ~a, ~b, ~c);
  endtask

  // Inputs are scrambled every ADD cycle; captured operands must win.
  task automatic addPhase();
    for (int i = 0; i < NIBBLES; i++) begin
      checkOutput("out_valid_during_add", 32'(out_valid), 32'd0);
      checkOutput("busy_during_add", 32'(busy), 32'd1);
      applyRandomNoise();
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    checkOutput("out_valid_at_latency", 32'(out_valid), 32'd1);
    checkOutput("out_sum", 32'(out_sum), 32'(exp_sum));
    checkOutput("out_carry", 32'(out_carry), 32'(exp_carry));
    checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic donePhase(input int hold, input logic drive_new,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (drive_new) applyStimulus(1'b1, a, b, c);
      else applyRandomNoise();
      tick();
      checkOutput("held_out_valid", 32'(out_valid), 32'd1);
      checkOutput("held_out_sum", 32'(out_sum), 32'(exp_sum));
      checkOutput("held_out_carry", 32'(out_carry), 32'(exp_carry));
      checkOutput("held_in_ready", 32'(in_ready), 32'd0);
    end
    if (drive_new) applyStimulus(1'b1, a, b, c);
    else applyStimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    out_ready = 1'b1;
    tick();
    checkOutput("handoff_out_valid", 32'(out_valid), 32'd0);
    checkOutput("handoff_in_ready", 32'(in_ready), 32'd1);
    checkOutput("handoff_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic fullOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int hold);
    acceptOp(a, b, c);
    addPhase();
    donePhase(hold, 1'b0, '0, '0, 1'b0);
  endtask

  logic [WIDTH-1:0] dir_a [6];
  logic [WIDTH-1:0] dir_b [6];
  logic             dir_c [6];

  initial begin
    dir_a = '{16'h0001, 16'hFFFF, 16'h0FFF, 16'h7A35, 16'h8000, 16'h1234};
    dir_b = '{16'h0001, 16'h0001, 16'h0000, 16'h15CB, 16'h8000, 16'h4321};
    dir_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
    checkOutput("reset_out_carry", 32'(out_carry), 32'd0);

    // Directed values, including full ripple and top-nibble carry-out.
    for (int i = 0; i < 6; i++) fullOp(dir_a[i], dir_b[i], dir_c[i], 0);
    checkOutput("known_sum_0x5555", 32'(exp_sum), 32'h5555);

    // Backpressure with new operands waiting, then accepted right after handoff.
    acceptOp(16'h1111, 16'h2222, 1'b0);
    addPhase();
    donePhase(5, 1'b1, 16'hABCD, 16'h1234, 1'b1);
    tick();
    setExpected(16'hABCD, 16'h1234, 1'b1);
    checkOutput("accept_after_handoff", 32'(busy), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    addPhase();
    donePhase(0, 1'b0, '0, '0, 1'b0);

    // Reset after two ADD cycles discards the operation.
    acceptOp(16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    tick();
    checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midop_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midop_reset_out_sum", 32'(out_sum), 32'd0);
    checkOutput("midop_reset_out_carry", 32'(out_carry), 32'd0);
    checkOutput("midop_reset_busy", 32'(busy), 32'd0);
    checkOutput("midop_reset_in_ready", 32'(in_ready), 32'd1);
    fullOp(16'h1234, 16'h4321, 1'b0, 1);

    for (int n = 0; n < 1000; n++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      fullOp(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
